// File: rtl/band_power_meter.sv
// Per-band magnitude accumulator feeding ten 12-bit bar heights, refreshed on a display request.
// Latency: request edge E0 snapshots/clears; bins 1..10 written on E1..E10, values_updated pulses after E10.
// Backpressure: none; one sample per cycle always accepted, requests seen while busy are dropped and flag overrun.
module band_power_meter #(
    parameter int SHIFT = 8,
    parameter int DECAY = 64,
    parameter int ACC_W = 32
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        band_valid,
    input  logic [3:0]  band_idx,
    input  logic [15:0] band_sample,
    input  logic        set_values_flag,
    output logic [11:0] bin1_out,
    output logic [11:0] bin2_out,
    output logic [11:0] bin3_out,
    output logic [11:0] bin4_out,
    output logic [11:0] bin5_out,
    output logic [11:0] bin6_out,
    output logic [11:0] bin7_out,
    output logic [11:0] bin8_out,
    output logic [11:0] bin9_out,
    output logic [11:0] bin10_out,
    output logic        values_updated,
    output logic        busy,
    output logic        overrun
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DUMP = 1'b1;

    // Decays larger than full scale behave the same as full scale.
    localparam int         DECAY_C  = (DECAY > 4096) ? 4096 : DECAY;
    localparam logic [12:0] DECAY_13 = 13'(DECAY_C);

    logic [0:0]       state;
    logic [3:0]       k;
    logic [ACC_W-1:0] acc   [10];
    logic [ACC_W-1:0] snap  [10];
    logic [11:0]      bin_q [10];

    logic [16:0]      sext;
    logic [16:0]      mag;
    logic             hit;
    logic             start;
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_sum;

    logic [ACC_W-1:0] snap_sel;
    logic [ACC_W-1:0] shifted;
    logic [11:0]      n_val;
    logic [11:0]      o_val;
    logic [11:0]      floor_val;
    logic [11:0]      bin_next;

    always_comb begin
        sext     = {band_sample[15], band_sample};
        mag      = sext[16] ? (~sext + 17'd1) : sext;
        hit      = band_valid && (band_idx < 4'd10);
        start    = (state == S_IDLE) && set_values_flag;
        acc_sel  = '0;
        for (int i = 0; i < 10; i++) begin
            if (band_idx == 4'(i)) acc_sel = acc[i];
        end
        sum_wide = {1'b0, acc_sel} + (ACC_W+1)'(mag);
        acc_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end

    always_comb begin
        snap_sel = '0;
        o_val    = '0;
        for (int i = 0; i < 10; i++) begin
            if (k == 4'(i)) begin
                snap_sel = snap[i];
                o_val    = bin_q[i];
            end
        end
        shifted   = snap_sel >> SHIFT;
        n_val     = (shifted > ACC_W'(4095)) ? 12'hFFF : shifted[11:0];
        floor_val = ({1'b0, o_val} > DECAY_13) ? (o_val - DECAY_13[11:0]) : 12'd0;
        // A zero decay means the bar tracks the new value directly, up or down.
        if (DECAY == 0)
            bin_next = n_val;
        else if (n_val >= o_val)
            bin_next = n_val;
        else
            bin_next = (n_val > floor_val) ? n_val : floor_val;
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            k              <= '0;
            values_updated <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                acc[i]   <= '0;
                snap[i]  <= '0;
                bin_q[i] <= '0;
            end
        end else begin
            values_updated <= 1'b0;
            // A sample landing on the request edge starts the new window.
            for (int i = 0; i < 10; i++) begin
                if (start)
                    acc[i] <= (hit && band_idx == 4'(i)) ? ACC_W'(mag) : '0;
                else if (hit && band_idx == 4'(i))
                    acc[i] <= acc_sum;
            end
            case (state)
                S_IDLE: begin
                    if (set_values_flag) begin
                        for (int i = 0; i < 10; i++) snap[i] <= acc[i];
                        k     <= '0;
                        state <= S_DUMP;
                    end
                end
                default: begin
                    if (set_values_flag) overrun <= 1'b1;
                    for (int i = 0; i < 10; i++) begin
                        if (k == 4'(i)) bin_q[i] <= bin_next;
                    end
                    if (k == 4'd9) begin
                        state          <= S_IDLE;
                        values_updated <= 1'b1;
                    end
                    k <= k + 4'd1;
                end
            endcase
        end
    end

    assign busy      = (state == S_DUMP);
    assign bin1_out  = bin_q[0];
    assign bin2_out  = bin_q[1];
    assign bin3_out  = bin_q[2];
    assign bin4_out  = bin_q[3];
    assign bin5_out  = bin_q[4];
    assign bin6_out  = bin_q[5];
    assign bin7_out  = bin_q[6];
    assign bin8_out  = bin_q[7];
    assign bin9_out  = bin_q[8];
    assign bin10_out = bin_q[9];

endmodule

// File: tb/tb_band_power_meter.sv
// Bench for band_power_meter: table of windows, hand-written corner sequences and a random phase,
// all compared every cycle against a window-level model, with a DECAY=0 instance alongside.
module tb_band_power_meter;

    localparam longint ACC_MAX = 64'hFFFF_FFFF;

    logic        sample_clk = 1'b0;
    logic        rst_n;
    logic        band_valid;
    logic [3:0]  band_idx;
    logic [15:0] band_sample;
    logic        set_values_flag;
    logic [11:0] b64 [10];
    logic [11:0] b0  [10];
    logic        vu, bsy, ovr, vu0, bsy0, ovr0;

    always #5 sample_clk = ~sample_clk;

    band_power_meter u_dut (
        .sample_clk(sample_clk), .rst_n(rst_n), .band_valid(band_valid), .band_idx(band_idx),
        .band_sample(band_sample), .set_values_flag(set_values_flag),
        .bin1_out(b64[0]), .bin2_out(b64[1]), .bin3_out(b64[2]), .bin4_out(b64[3]), .bin5_out(b64[4]),
        .bin6_out(b64[5]), .bin7_out(b64[6]), .bin8_out(b64[7]), .bin9_out(b64[8]), .bin10_out(b64[9]),
        .values_updated(vu), .busy(bsy), .overrun(ovr)
    );

    band_power_meter #(.DECAY(0)) u_dut0 (
        .sample_clk(sample_clk), .rst_n(rst_n), .band_valid(band_valid), .band_idx(band_idx),
        .band_sample(band_sample), .set_values_flag(set_values_flag),
        .bin1_out(b0[0]), .bin2_out(b0[1]), .bin3_out(b0[2]), .bin4_out(b0[3]), .bin5_out(b0[4]),
        .bin6_out(b0[5]), .bin7_out(b0[6]), .bin8_out(b0[7]), .bin9_out(b0[8]), .bin10_out(b0[9]),
        .values_updated(vu0), .busy(bsy0), .overrun(ovr0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int vu_count = 0;

    // Window-level model: running sums, bar heights, and the edge count since the last honoured request.
    longint m_acc [10];
    int     m_b64 [10];
    int     m_b0  [10];
    int     m_n64 [10];
    int     m_n0  [10];
    int     m_d;
    bit     m_ovr;

    typedef struct {
        int idx;
        int smp;
        int cnt;
        int chk;
        int e64;
        int e0;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [122:0] act, input logic [122:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_acc[i] = 0; m_b64[i] = 0; m_b0[i] = 0; m_n64[i] = 0; m_n0[i] = 0;
        end
        m_d   = 100;
        m_ovr = 1'b0;
    endtask

    task automatic check_all();
        logic [119:0] eb, ab, eb0, ab0;
        logic ev, ebsy;
        for (int i = 0; i < 10; i++) begin
            eb[i*12 +: 12]  = 12'(m_b64[i]);
            eb0[i*12 +: 12] = 12'(m_b0[i]);
            ab[i*12 +: 12]  = b64[i];
            ab0[i*12 +: 12] = b0[i];
        end
        ev   = (m_d == 10);
        ebsy = (m_d <= 9);
        chk_vec("outputs_decay64", {ab, vu, bsy, ovr}, {eb, ev, ebsy, m_ovr});
        chk_vec("outputs_decay0", {ab0, vu0, bsy0, ovr0}, {eb0, ev, ebsy, m_ovr});
    endtask

    task automatic step(input bit v, input int idx, input int s, input bit req);
        longint n;
        int o, fl;
        band_valid      = v;
        band_idx        = 4'(idx);
        band_sample     = 16'(s);
        set_values_flag = req;
        @(posedge sample_clk);
        if (req && m_d <= 9) m_ovr = 1'b1;
        if (req && m_d > 9) begin
            for (int i = 0; i < 10; i++) begin
                n  = m_acc[i] / 256;
                if (n > 4095) n = 4095;
                o  = m_b64[i];
                fl = (o - 64 < 0) ? 0 : o - 64;
                m_n64[i] = (n >= o) ? int'(n) : ((n > fl) ? int'(n) : fl);
                m_n0[i]  = int'(n);
                m_acc[i] = 0;
            end
            m_d = 0;
        end else if (m_d < 100) begin
            m_d++;
        end
        if (v && idx >= 0 && idx < 10) begin
            m_acc[idx] += (s < 0) ? -s : s;
            if (m_acc[idx] > ACC_MAX) m_acc[idx] = ACC_MAX;
        end
        if (m_d >= 1 && m_d <= 10) begin
            m_b64[m_d-1] = m_n64[m_d-1];
            m_b0[m_d-1]  = m_n0[m_d-1];
        end
        #1;
        if (vu) vu_count++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{0,    256,   100, 0, 100,  100};
        tbl[1] = '{3,   -512,  1000, 3, 2000, 2000};
        tbl[2] = '{5, -32768,     1, 5, 128,  128};
        tbl[3] = '{0,      0,     0, 3, 1872, 0};
        tbl[4] = '{9,  32767, 40000, 9, 4095, 4095};
        tbl[5] = '{12,  1000,    50, 9, 4031, 0};

        rst_n = 1'b0; band_valid = 1'b0; band_idx = '0; band_sample = '0; set_values_flag = 1'b0;
        model_reset();
        repeat (2) @(posedge sample_clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Table of windows: fill, request, let the dump finish, then check one band's bar.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < tbl[r].cnt; i++) step(1'b1, tbl[r].idx, tbl[r].smp, 1'b0);
            vu_count = 0;
            step(1'b0, 0, 0, 1'b1);
            idle(11);
            chk($sformatf("tbl%0d_bin%0d_d64", r, tbl[r].chk + 1), b64[tbl[r].chk], tbl[r].e64);
            chk($sformatf("tbl%0d_bin%0d_d0", r, tbl[r].chk + 1), b0[tbl[r].chk], tbl[r].e0);
            chk($sformatf("tbl%0d_vu_pulses", r), vu_count, 1);
        end

        // Sample on the request edge belongs to the following window.
        step(1'b1, 2, 1024, 1'b1);
        idle(11);
        chk("same_cycle_first_bin3", b64[2], 0);
        step(1'b0, 0, 0, 1'b1);
        idle(11);
        chk("same_cycle_second_bin3", b64[2], 4);
        chk("same_cycle_second_bin3_d0", b0[2], 4);

        // Second request at E5 is dropped, flags overrun and keeps the accumulators.
        vu_count = 0;
        step(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 2560, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        chk("overrun_set", ovr, 1);
        idle(10);
        chk("overrun_vu_pulses", vu_count, 1);
        step(1'b0, 0, 0, 1'b1);
        idle(11);
        chk("overrun_not_cleared_bin2", b64[1], 30);

        // Reset at E4 of a dump clears everything asynchronously.
        for (int i = 0; i < 5; i++) step(1'b1, 4, 256, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        idle(4);
        chk("pre_reset_bin10_nonzero", (b64[9] != 0) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        begin
            logic [119:0] ab;
            for (int i = 0; i < 10; i++) ab[i*12 +: 12] = b64[i];
            chk_vec("async_reset_outputs", {ab, vu, bsy, ovr}, 123'd0);
        end
        model_reset();
        repeat (2) @(posedge sample_clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 4, 256, 1'b0);
        vu_count = 0;
        step(1'b0, 0, 0, 1'b1);
        idle(11);
        chk("post_reset_bin5", b64[4], 7);
        chk("post_reset_vu_pulses", vu_count, 1);

        // Random traffic with occasional requests, some of which land mid-dump.
        for (int i = 0; i < 3000; i++) begin
            int s;
            s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 600)) - 300;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), s,
                 $urandom_range(0, 39) == 0);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
